// File: rtl/ifu_fetch_if.sv
// Fetch-stage bus: instruction-memory request/response port plus the core-facing instruction port.
// The fetch unit uses the master modport; memory and core models use the slave modport.
interface ifu_fetch_if #(
    parameter int XLEN = 64
);
    logic [XLEN-1:0] pc;
    logic            flush;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [31:0]     imem_resp_data;
    logic            imem_resp_err;
    logic            inst_valid;
    logic            inst_ready;
    logic [31:0]     inst;
    logic [XLEN-1:0] inst_pc;
    logic            inst_is_ebreak;
    logic [1:0]      fetch_fault;
    logic [31:0]     fetch_count;

    modport master (
        input  pc, flush, imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
               inst_ready,
        output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, inst_is_ebreak,
               fetch_fault, fetch_count
    );

    modport slave (
        output pc, flush, imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
               inst_ready,
        input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, inst_is_ebreak,
               fetch_fault, fetch_count
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: one outstanding imem request, holds the fetched word for the core,
// and reports misaligned / memory-error / timeout faults with a retired-fetch counter.
module ifu_fetch #(
    parameter int          XLEN        = 64,
    parameter int          TIMEOUT     = 255,
    parameter logic [31:0] EBREAK_INST = 32'h0010_0073
) (
    input  logic        clk,
    input  logic        rst,
    ifu_fetch_if.master bus
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} state_e;

    localparam logic [1:0]  FAULT_NONE     = 2'd0;
    localparam logic [1:0]  FAULT_MISALIGN = 2'd1;
    localparam logic [1:0]  FAULT_MEMERR   = 2'd2;
    localparam logic [1:0]  FAULT_TIMEOUT  = 2'd3;
    localparam logic [15:0] TMO_LAST       = 16'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [31:0]     inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic [1:0]      fault_q, fault_d;
    logic [15:0]     tmo_q, tmo_d;
    logic            owed_q, owed_d;
    logic [31:0]     count_q, count_d;
    logic            misaligned;
    logic            req_fire;

    assign misaligned = bus.pc[1:0] != 2'b00;
    assign req_fire   = bus.imem_req_valid && bus.imem_req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            inst_q    <= '0;
            inst_pc_q <= '0;
            fault_q   <= FAULT_NONE;
            tmo_q     <= '0;
            owed_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            fault_q   <= fault_d;
            tmo_q     <= tmo_d;
            owed_q    <= owed_d;
            count_q   <= count_d;
        end
    end

    // owed_q is only ever set in HOLD after a timeout; the late response clears it wherever it lands.
    always_comb begin
        state_d   = state_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        fault_d   = fault_q;
        tmo_d     = tmo_q;
        owed_d    = owed_q && !bus.imem_resp_valid;
        count_d   = count_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (req_fire) begin
                    inst_pc_d = bus.pc;
                    tmo_d     = '0;
                    state_d   = bus.flush ? DRAIN : WAIT;
                end else if (!bus.flush && misaligned) begin
                    inst_pc_d = bus.pc;
                    inst_d    = '0;
                    fault_d   = FAULT_MISALIGN;
                    state_d   = HOLD;
                end
            end
            WAIT: begin
                if (bus.flush) begin
                    state_d = bus.imem_resp_valid ? REQ : DRAIN;
                end else if (bus.imem_resp_valid) begin
                    inst_d  = bus.imem_resp_err ? 32'h0 : bus.imem_resp_data;
                    fault_d = bus.imem_resp_err ? FAULT_MEMERR : FAULT_NONE;
                    state_d = HOLD;
                end else if (tmo_q == TMO_LAST) begin
                    inst_d  = '0;
                    fault_d = FAULT_TIMEOUT;
                    owed_d  = 1'b1;
                    state_d = HOLD;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            HOLD: begin
                // Flush wins over inst_ready: the instruction leaves without being counted.
                if (bus.flush || bus.inst_ready) begin
                    state_d = (owed_q && !bus.imem_resp_valid) ? DRAIN : REQ;
                    owed_d  = 1'b0;
                    if (!bus.flush) begin
                        count_d = count_q + 32'd1;
                    end
                end
            end
            DRAIN: begin
                if (bus.imem_resp_valid) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.imem_req_valid = 1'b0;
        bus.imem_req_addr  = '0;
        bus.inst_valid     = 1'b0;
        bus.inst_is_ebreak = 1'b0;
        if (state_q == REQ) begin
            bus.imem_req_valid = !misaligned;
            bus.imem_req_addr  = bus.pc;
        end
        if (state_q == HOLD) begin
            bus.inst_valid     = 1'b1;
            bus.inst_is_ebreak = (fault_q == FAULT_NONE) && (inst_q == EBREAK_INST);
        end
    end

    assign bus.inst        = inst_q;
    assign bus.inst_pc     = inst_pc_q;
    assign bus.fetch_fault = fault_q;
    assign bus.fetch_count = count_q;
endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch: each fetch pushes its expected instruction/pc/fault,
// which is popped and compared when the stage presents inst_valid.
module tb_ifu_fetch;
    localparam int          XLEN   = 64;
    localparam int          TMO    = 4;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic [1:0]      fault;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   expCount = 0;
    exp_t sb[$];

    ifu_fetch_if #(.XLEN(XLEN)) bus ();

    ifu_fetch #(.XLEN(XLEN), .TIMEOUT(TMO), .EBREAK_INST(EBREAK)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idleInputs();
        bus.flush           = 1'b0;
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        bus.imem_resp_err   = 1'b0;
        bus.inst_ready      = 1'b0;
    endtask

    task automatic nextCycle();
        @(negedge clk);
        idleInputs();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_req_valid"}, bus.imem_req_valid, 0);
        checkOutput({tag, "_req_addr"}, bus.imem_req_addr, 0);
        checkOutput({tag, "_inst_valid"}, bus.inst_valid, 0);
        checkOutput({tag, "_inst"}, bus.inst, 0);
        checkOutput({tag, "_inst_pc"}, bus.inst_pc, 0);
        checkOutput({tag, "_fault"}, bus.fetch_fault, 0);
        checkOutput({tag, "_ebreak"}, bus.inst_is_ebreak, 0);
        checkOutput({tag, "_count"}, bus.fetch_count, 0);
    endtask

    task automatic waitInst();
        exp_t e;
        int   waited = 0;
        do begin
            nextCycle();
            #1;
            waited++;
        end while (!bus.inst_valid && waited < 20);
        checkOutput("inst_valid", bus.inst_valid, 1);
        checkOutput("latency", waited, 1);
        e = sb.pop_front();
        checkOutput("inst", bus.inst, e.inst);
        checkOutput("inst_pc", bus.inst_pc, e.pc);
        checkOutput("fault", bus.fetch_fault, e.fault);
        checkOutput("ebreak", bus.inst_is_ebreak, (e.fault == 2'd0) && (e.inst == EBREAK));
    endtask

    // Starts in the REQ cycle; noResp leaves the response owed past the timeout.
    task automatic applyStimulus(input logic [XLEN-1:0] p, input int stall, input int delay,
                                 input logic [31:0] data, input logic err, input bit noResp);
        exp_t e;
        bit   mis;
        mis     = (p[1:0] != 2'b00);
        e.pc    = p;
        e.fault = mis ? 2'd1 : err ? 2'd2 : (delay >= TMO || noResp) ? 2'd3 : 2'd0;
        e.inst  = (e.fault == 2'd0) ? data : 32'h0;
        sb.push_back(e);
        nextCycle();
        bus.pc = p;
        if (mis) begin
            #1;
            checkOutput("req_valid_misaligned", bus.imem_req_valid, 0);
        end else begin
            for (int i = 0; i < stall; i++) begin
                #1;
                checkOutput("req_valid_stall", bus.imem_req_valid, 1);
                checkOutput("req_addr_stall", bus.imem_req_addr, p);
                nextCycle();
            end
            bus.imem_req_ready = 1'b1;
            #1;
            checkOutput("req_valid", bus.imem_req_valid, 1);
            checkOutput("req_addr", bus.imem_req_addr, p);
            for (int i = 0; i < delay; i++) begin
                nextCycle();
                #1;
                checkOutput("inst_valid_during_wait", bus.inst_valid, (i >= TMO));
            end
            if (!noResp) begin
                nextCycle();
                bus.imem_resp_valid = 1'b1;
                bus.imem_resp_data  = data;
                bus.imem_resp_err   = err;
                #1;
                if (delay < TMO) begin
                    checkOutput("inst_valid_resp_cycle", bus.inst_valid, 0);
                end
            end
        end
        waitInst();
    endtask

    task automatic retire(input bit withFlush);
        nextCycle();
        bus.inst_ready = 1'b1;
        bus.flush      = withFlush;
        #1;
        checkOutput("inst_valid_pre_retire", bus.inst_valid, 1);
        if (!withFlush) begin
            expCount++;
        end
        @(posedge clk);
        #1;
        idleInputs();
        checkOutput("fetch_count", bus.fetch_count, expCount);
        checkOutput("inst_valid_post_retire", bus.inst_valid, 0);
    endtask

    // Owed response arrives after n quiet cycles; no new request may appear meanwhile.
    task automatic drainResp(input int n);
        for (int i = 0; i < n; i++) begin
            nextCycle();
            #1;
            checkOutput("drain_no_req", bus.imem_req_valid, 0);
        end
        nextCycle();
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = 32'hDEAD_BEEF;
        #1;
        checkOutput("drain_no_req_resp", bus.imem_req_valid, 0);
    endtask

    task automatic flushInWait(input logic [XLEN-1:0] p);
        nextCycle();
        bus.pc             = p;
        bus.imem_req_ready = 1'b1;
        #1;
        checkOutput("flush_req_valid", bus.imem_req_valid, 1);
        nextCycle();
        bus.flush = 1'b1;
        #1;
        checkOutput("flush_wait_inst_valid", bus.inst_valid, 0);
        drainResp(2);
    endtask

    task automatic resetInWait(input logic [XLEN-1:0] p);
        nextCycle();
        bus.pc             = p;
        bus.imem_req_ready = 1'b1;
        #1;
        checkOutput("rst_req_valid", bus.imem_req_valid, 1);
        nextCycle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkAllZero("rst_mid_wait");
        expCount = 0;
        nextCycle();
        rst = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        bus.pc = '0;
        idleInputs();
        @(posedge clk);
        #1;
        checkAllZero("reset");
        nextCycle();
        rst    = 1'b0;
        bus.pc = 64'h8000_0000;
        #1;
        checkOutput("idle_no_req", bus.imem_req_valid, 0);

        applyStimulus(64'h8000_0000, 0, 0, 32'h0000_0413, 1'b0, 1'b0);
        retire(1'b0);
        applyStimulus(64'h8000_0004, 0, 0, EBREAK, 1'b0, 1'b0);
        retire(1'b0);
        applyStimulus(64'h8000_0002, 0, 0, 32'h0000_0013, 1'b0, 1'b0);
        retire(1'b0);
        applyStimulus(64'h8000_0008, 5, 0, EBREAK, 1'b1, 1'b0);
        retire(1'b0);
        applyStimulus(64'h8000_000C, 0, 2, 32'h0010_0093, 1'b0, 1'b0);
        retire(1'b0);

        flushInWait(64'h8000_0010);
        applyStimulus(64'h8000_0010, 0, 0, 32'h00A0_0093, 1'b0, 1'b0);
        retire(1'b1);
        applyStimulus(64'h8000_0010, 0, 0, 32'h00B0_0113, 1'b0, 1'b0);
        retire(1'b0);

        applyStimulus(64'h8000_0014, 0, 6, 32'hDEAD_BEEF, 1'b0, 1'b0);
        retire(1'b0);
        applyStimulus(64'h8000_0018, 0, 0, 32'h00C0_0193, 1'b0, 1'b0);
        retire(1'b0);

        applyStimulus(64'h8000_001C, 0, TMO, 32'h0, 1'b0, 1'b1);
        retire(1'b0);
        drainResp(1);
        applyStimulus(64'h8000_0020, 0, 1, 32'h00D0_0213, 1'b0, 1'b0);
        retire(1'b0);

        resetInWait(64'h8000_0024);
        applyStimulus(64'h8000_0024, 0, 0, 32'h00E0_0293, 1'b0, 1'b0);
        retire(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
